// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared epic_racer definitions for the sprite ROM path: geometry, requester ids, ROM latency.
// Also holds the modulo-N index helper used by the round-robin pointer.
package sprite_rom_arbiter_pkg;

  localparam int SPR_ADDR_W  = 12;
  localparam int SPR_DATA_W  = 12;
  localparam int SPR_ROM_LAT = 1;
  localparam int SPR_N_REQ   = 4;

  localparam int REQ_PLAYER = 0;
  localparam int REQ_RIVAL  = 1;
  localparam int REQ_TRACK  = 2;
  localparam int REQ_HUD    = 3;

  // Explicit wrap so non-power-of-two requester counts stay in range.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping modulo N_REQ.
// Zero latency; no backpressure of its own.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_win,
  output logic             o_any
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_win = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(N_REQ);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_win        = w_idx;
        o_gnt[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of one sprite ROM port; grant is combinational, data returns ROM_LAT+1 cycles later.
// One grant per cycle; losers simply hold req/addr until granted.
module sprite_rom_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int N_REQ   = SPR_N_REQ,
  parameter int ADDR_W  = SPR_ADDR_W,
  parameter int DATA_W  = SPR_DATA_W,
  parameter int ROM_LAT = SPR_ROM_LAT
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_vs,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*ADDR_W-1:0] i_addr,
  output logic [N_REQ-1:0]        o_gnt,
  output logic                    o_rom_en,
  output logic [ADDR_W-1:0]       o_rom_addr,
  input  logic [DATA_W-1:0]       i_rom_data,
  output logic [N_REQ-1:0]        o_rd_valid,
  output logic [DATA_W-1:0]       o_rd_data
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int DEPTH = ROM_LAT + 1;

  logic [IDX_W-1:0]            r_ptr;
  logic [IDX_W-1:0]            w_ptr_nxt;
  logic [IDX_W-1:0]            w_win;
  logic [N_REQ-1:0]            w_gnt;
  logic                        w_any;
  logic                        r_prev_vs;
  logic                        w_fall;
  logic                        r_rom_en;
  logic [ADDR_W-1:0]           r_rom_addr;
  logic [DEPTH-1:0]            r_tag_vld;
  logic [DEPTH-1:0][IDX_W-1:0] r_tag_id;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_win (w_win),
    .o_any (w_any)
  );

  assign o_gnt  = i_rst ? w_gnt : '0;
  assign w_fall = r_prev_vs & ~i_vs;

  // Frame start wins over the post-grant advance so every frame begins at requester 0.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_fall) begin
      w_ptr_nxt = '0;
    end else if (w_any) begin
      w_ptr_nxt = IDX_W'(wrap_inc(int'(w_win), N_REQ));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ptr      <= '0;
      r_prev_vs  <= 1'b1;
      r_rom_en   <= 1'b0;
      r_rom_addr <= '0;
      r_tag_vld  <= '0;
      r_tag_id   <= '0;
    end else begin
      r_ptr     <= w_ptr_nxt;
      r_prev_vs <= i_vs;
      r_rom_en  <= w_any;
      if (w_any) begin
        r_rom_addr <= i_addr[w_win*ADDR_W +: ADDR_W];
      end
      r_tag_vld <= {r_tag_vld[DEPTH-2:0], w_any};
      r_tag_id  <= {r_tag_id[DEPTH-2:0], w_win};
    end
  end

  always_comb begin
    o_rd_valid = '0;
    if (r_tag_vld[DEPTH-1]) begin
      o_rd_valid[r_tag_id[DEPTH-1]] = 1'b1;
    end
  end

  assign o_rom_en   = r_rom_en;
  assign o_rom_addr = r_rom_addr;
  assign o_rd_data  = i_rom_data;

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite/colour ROM read port between up to N_REQ pixel-drawing requesters (player car, rival cars, track, HUD) inside epic_racer.
- Arbitration is round-robin, one access per cycle.
- Each grant is tagged, so the returned ROM word is steered to the requester that issued it after a fixed latency.
- The round-robin pointer re-aligns at every frame start (falling edge of vs), so grant order is deterministic frame to frame.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 12, ROM address width.
- DATA_W, 12, ROM word width (4:4:4 RGB).
- ROM_LAT, 1, ROM read latency in cycles from rom_en to rom_data (1..3).

Ports:
- clk  in  1  pixel-domain clock.
- rst  in  1  reset; asynchronous, active-low.
- vs  in  1  vertical sync from the timing generator; falling edge = frame start.
- req  in  N_REQ  per-requester read request; held until granted.
- addr  in  N_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]; held with req.
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as the winning req.
- rom_en  out  1  registered ROM read enable.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  DATA_W  ROM output, valid ROM_LAT cycles after rom_en.
- rd_valid  out  N_REQ  one-hot; marks rd_data as belonging to requester i.
- rd_data  out  DATA_W  rom_data passed through, qualified by rd_valid.

Behaviour:
- Reset (rst=0, async): rom_en=0, rom_addr=0, rd_valid=0, tag pipeline cleared, pointer=0, vs edge register=1. gnt stays combinational but is forced to 0 while rst=0.
- Pointer ptr holds the highest-priority index. Search order is ptr, ptr+1, …, N_REQ-1, 0, …, wrapping modulo N_REQ.
- Grant cycle t: the winner w is the first i in search order with req[i]=1, and gnt[w]=1. On the clk edge ending t: rom_en<=1, rom_addr<=addr[w], ptr<=(w+1) mod N_REQ, and tag (valid=1, id=w) enters the tag pipeline.
- No request in cycle t: gnt=0, rom_en<=0, ptr unchanged, an invalid tag enters the pipeline.
- Data return: rom_data for the grant in cycle t is present in cycle t+1+ROM_LAT. In that cycle rd_valid[w]=1 for exactly one cycle. rd_valid is driven from the registered tag pipeline (depth ROM_LAT+1); rd_data=rom_data combinationally.
- Throughput: one grant per cycle, back-to-back, with no bubbles. A requester may reassert in the cycle after its grant.
- Starvation bound: a continuously asserted req is granted within N_REQ cycles.
- Frame start: vs is sampled into a register, and fall = prev_vs & ~vs. On the edge where fall=1, ptr<=0, overriding the post-grant update. The grant already decided in that cycle still issues, and in-flight tags continue normally.
- Requester changing addr while req=1 and not granted: permitted; the address sampled is the one present in the grant cycle.
- Requester dropping req before grant: permitted; no grant and no rd_valid for it.
- Reset mid-operation: all in-flight tags are discarded; no rd_valid appears after rst deasserts for pre-reset grants.
- Index arithmetic: ptr and ids are $clog2(N_REQ) bits wide. Wrap is explicit modulo N_REQ, correct for non-power-of-two N_REQ (e.g. 3 or 5).

Decomposition:
- Shared constants file epic_racer_defs (include), holding:
  - sprite ROM ADDR_W and DATA_W;
  - requester index assignments (REQ_PLAYER=0, REQ_RIVAL=1, REQ_TRACK=2, REQ_HUD=3);
  - ROM_LAT of the instantiated ROM.
- One sub-module rr_pick: purely combinational round-robin picker. Inputs req and ptr; outputs one-hot gnt, winner index and any-valid.
- The top level holds ptr, the vs edge detector, the rom_addr/rom_en registers and the tag shift register.

Test Plan:
- Reset/idle: rst=0 for 3 cycles, then release with req=0 -> gnt, rom_en and rd_valid stay 0 for 20 cycles; rom_addr=0.
- Single requester, ROM_LAT=1: req[2]=1, addr[2]=0x123 held -> gnt[2]=1 every cycle; rom_addr=0x123 one cycle later. With ROM model data=~addr, rd_valid[2]=1 with rd_data=0xEDC two cycles after each grant.
- All four requesting continuously -> grant order 0,1,2,3,0,1,… one per cycle. Each rd_valid[i] carries that requester's own address-derived data, 2 cycles after its grant.
- Fairness/wrap, N_REQ=3: req=3'b101 constant after a grant to 2 -> next grants 0,2,0,2. Max gap per requester is no more than 3 cycles.
- Frame re-alignment: ptr=2 with all req=1, vs falls -> the cycle after the edge grants requester 0, not 3.
- Reset mid-flight, ROM_LAT=3: grant req[1] and assert rst=0 one cycle later for 1 cycle -> no rd_valid[1] ever appears for that grant; the next grant after release goes to requester 0.
